branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
- Sequencer for the ID-stage branch unit: detects data hazards on branch/jump source registers, stalls the front end for the required cycles, then enables branch resolution.
- Flushes IF/ID when the branch unit reports taken, and freezes the front end when debug disables stepping.
- Sits between the hazard/forwarding logic, the PC and IF/ID registers, and the branch unit's enable input.

Parameters:
- REG_ADDR_W, 5, register address width.
- EX_LOAD_STALL, 2, stall cycles when a load in EX writes a branch source.
- EX_ALU_STALL, 1, stall cycles when an ALU op in EX writes a branch source.
- MEM_LOAD_STALL, 1, stall cycles when a load in MEM writes a branch source.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  debug step enable; 0 freezes the front end.
- i_id_op  in  6  opcode of the instruction in ID.
- i_id_funct  in  6  funct field of the instruction in ID.
- i_id_rs  in  REG_ADDR_W  rs of the instruction in ID.
- i_id_rt  in  REG_ADDR_W  rt of the instruction in ID.
- i_ex_reg_write  in  1  EX instruction writes the register file.
- i_ex_mem_read  in  1  EX instruction is a load.
- i_ex_dst  in  REG_ADDR_W  EX destination register.
- i_mem_mem_read  in  1  MEM instruction is a load.
- i_mem_dst  in  REG_ADDR_W  MEM destination register.
- i_taken  in  1  taken flag from the branch unit (combinational).
- o_pc_write  out  1  PC load enable.
- o_ifid_write  out  1  IF/ID write enable.
- o_ifid_flush  out  1  IF/ID loads a NOP at the next edge.
- o_idex_bubble  out  1  ID/EX loads a NOP at the next edge.
- o_branch_en  out  1  enable to the branch unit.
- o_busy  out  1  1 while in STALL.
- o_taken_count  out  CNT_W  taken-branch count (optional feature).
- o_stall_count  out  CNT_W  stall-cycle count (optional feature).

Behaviour:
- Branch class decode:
  - BEQ (000100) and BNE (000101) use rs and rt.
  - JR and JALR (op 000000, funct 001000 or 001001) use rs only.
  - J (000010) and JAL (000011) use no sources.
  - Any other opcode is not a branch.
- A source register matches only if it is nonzero and equal to the destination.
- Stall count n, highest priority first:
  - EX hazard with i_ex_mem_read=1: n = EX_LOAD_STALL.
  - EX hazard with i_ex_reg_write=1: n = EX_ALU_STALL.
  - MEM load hazard: n = MEM_LOAD_STALL.
  - Otherwise n = 0.
  - ALU results in MEM are forwarded to ID and cause no stall.
- Stall outputs: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_branch_en=0, o_ifid_flush=0.
- Normal outputs: o_pc_write=1, o_ifid_write=1, o_idex_bubble=0, o_branch_en=1 if ID holds a branch, o_ifid_flush=o_branch_en & i_taken.
- FSM states IDLE and STALL, with a stall counter cnt of width clog2(max stall + 1).
- IDLE, branch in ID, n > 0:
  - Drive stall outputs this cycle.
  - If n > 1: cnt <= n-1 and go to STALL. Otherwise stay in IDLE.
- IDLE, otherwise: drive normal outputs.
- STALL:
  - Drive stall outputs and decrement cnt.
  - When cnt==1, go to IDLE. Hazards are re-evaluated in IDLE, so further stalls are possible.
- Taken branch: PC loads the jump address and IF/ID is flushed in the same cycle. Resolution adds 0 extra latency.
- i_enable=0 (any state):
  - o_pc_write=0, o_ifid_write=0, o_idex_bubble=0, o_branch_en=0, o_ifid_flush=0.
  - State and cnt hold.
  - Has priority over all other conditions.
- Reset (including mid-STALL): state=IDLE, cnt=0, counters=0.
  - While rst=1, all enable/flush/bubble outputs and o_busy are 0.
- A non-branch in ID never stalls, even if a register matches.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - o_taken_count increments on each cycle with o_ifid_flush=1.
  - o_stall_count increments on each stall-output cycle, excluding i_enable=0 cycles.
  - Both wrap at 2^CNT_W and clear on rst.
- Not defined: both counters are tied to 0. Ports remain present.

Test Plan:
- BEQ rs=3, rt=4 in ID, EX is a load with dst=3 -> 2 cycles of pc_write=0 and idex_bubble=1, o_busy=1 in cycle 2, branch_en=1 in cycle 3.
- BNE rs=5, EX ALU op with dst=5 -> exactly 1 stall cycle, then branch_en=1; i_taken=1 -> ifid_flush=1 for one cycle.
- JR rs=0, EX load with dst=0 -> no stall; J with EX dst=7 -> no stall, branch_en=1.
- ADD in ID with EX load dst matching rs -> no stall, branch_en=0.
- Reset asserted in the STALL state -> next cycle IDLE, outputs 0 while rst=1, counters 0.
- i_enable=0 during a 2-cycle load stall -> outputs frozen, state held; stall completes after i_enable returns. With BRANCH_STATS_EN, o_stall_count=2.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls on branch-source hazards, enables resolution, flushes IF/ID on taken.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int EX_LOAD_STALL  = 2,
  parameter int EX_ALU_STALL   = 1,
  parameter int MEM_LOAD_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [5:0]            i_id_op,
  input  logic [5:0]            i_id_funct,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_dst,
  input  logic                  i_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_dst,
  input  logic                  i_taken,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic                  o_branch_en,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_taken_count,
  output logic [CNT_W-1:0]      o_stall_count
);

  localparam int MAX_A     = (EX_LOAD_STALL > EX_ALU_STALL) ? EX_LOAD_STALL : EX_ALU_STALL;
  localparam int MAX_STALL = (MAX_A > MEM_LOAD_STALL) ? MAX_A : MEM_LOAD_STALL;
  localparam int CW        = (MAX_STALL > 1) ? $clog2(MAX_STALL + 1) : 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_n;
  logic          w_is_br, w_use_rs, w_use_rt;
  logic          w_ex_match, w_mem_match;

  always_comb begin
    w_is_br  = 1'b0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (i_id_op)
      6'b000100, 6'b000101: begin
        w_is_br  = 1'b1;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'b000010, 6'b000011: w_is_br = 1'b1;
      6'b000000: begin
        if (i_id_funct == 6'b001000 || i_id_funct == 6'b001001) begin
          w_is_br  = 1'b1;
          w_use_rs = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // r0 is hardwired zero, so it never creates a dependency
  assign w_ex_match  = (w_use_rs && i_id_rs != '0 && i_id_rs == i_ex_dst) ||
                       (w_use_rt && i_id_rt != '0 && i_id_rt == i_ex_dst);
  assign w_mem_match = (w_use_rs && i_id_rs != '0 && i_id_rs == i_mem_dst) ||
                       (w_use_rt && i_id_rt != '0 && i_id_rt == i_mem_dst);

  // MEM-stage ALU results are forwarded to ID, so only a MEM load stalls
  always_comb begin
    if (w_ex_match && i_ex_mem_read)        w_n = CW'(EX_LOAD_STALL);
    else if (w_ex_match && i_ex_reg_write)  w_n = CW'(EX_ALU_STALL);
    else if (w_mem_match && i_mem_mem_read) w_n = CW'(MEM_LOAD_STALL);
    else                                    w_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_branch_en   = 1'b0;
    if (!rst && i_enable) begin
      case (r_state)
        IDLE: begin
          if (w_is_br && w_n != '0) begin
            o_idex_bubble = 1'b1;
            if (w_n > CW'(1)) begin
              w_cnt_nxt   = w_n - CW'(1);
              w_state_nxt = STALL;
            end
          end else begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_branch_en  = w_is_br;
            o_ifid_flush = w_is_br & i_taken;
          end
        end
        STALL: begin
          o_idex_bubble = 1'b1;
          w_cnt_nxt     = r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_busy = !rst && (r_state == STALL);

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_count, r_stall_count;

  // a bubble is driven only on enabled stall cycles, so it marks exactly the cycles to count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (o_ifid_flush)  r_taken_count <= r_taken_count + CNT_W'(1);
      if (o_idex_bubble) r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_taken_count = r_taken_count;
  assign o_stall_count = r_stall_count;
`else
  assign o_taken_count = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed-vector bench for branch_hazard_ctrl; outputs checked as {pc,ifid,flush,bubble,br_en,busy}.
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, i_enable, i_ex_reg_write, i_ex_mem_read, i_mem_mem_read, i_taken;
  logic [5:0]  i_id_op, i_id_funct;
  logic [4:0]  i_id_rs, i_id_rt, i_ex_dst, i_mem_dst;
  logic        o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_branch_en, o_busy;
  logic [31:0] o_taken_count, o_stall_count;

  int n_vec = 0;
  int n_err = 0;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [5:0] O_ZERO  = 6'b000000;
  localparam logic [5:0] O_NORM  = 6'b110000;
  localparam logic [5:0] O_BR    = 6'b110010;
  localparam logic [5:0] O_TAKEN = 6'b111010;
  localparam logic [5:0] O_STL   = 6'b000100;
  localparam logic [5:0] O_STLB  = 6'b000101;
  localparam logic [5:0] O_FRZB  = 6'b000001;

  branch_hazard_ctrl dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_id_op(i_id_op), .i_id_funct(i_id_funct), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_dst(i_ex_dst),
    .i_mem_mem_read(i_mem_mem_read), .i_mem_dst(i_mem_dst), .i_taken(i_taken),
    .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush),
    .o_idex_bubble(o_idex_bubble), .o_branch_en(o_branch_en), .o_busy(o_busy),
    .o_taken_count(o_taken_count), .o_stall_count(o_stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_branch_en, o_busy},
        {26'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt);
    i_id_op = op; i_id_funct = fn; i_id_rs = rs; i_id_rt = rt;
  endtask

  task automatic ex(input logic rw, input logic mr, input logic [4:0] dst);
    i_ex_reg_write = rw; i_ex_mem_read = mr; i_ex_dst = dst;
  endtask

  task automatic mem(input logic mr, input logic [4:0] dst);
    i_mem_mem_read = mr; i_mem_dst = dst;
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_taken = 1'b0;
    id(6'b000100, 6'd0, 5'd3, 5'd4); ex(1'b1, 1'b1, 5'd3); mem(1'b0, 5'd0);
    cyc(); cyc();
    outs("reset_outs", O_ZERO);
    chk("reset_taken_cnt", o_taken_count, 32'd0);
    chk("reset_stall_cnt", o_stall_count, 32'd0);

    // idle with ADD in ID
    rst = 1'b0; id(6'b000000, 6'b100000, 5'd1, 5'd2); ex(1'b0, 1'b0, 5'd0);
    outs("idle_add", O_NORM);

    // BEQ behind an EX load: two stall cycles, then resolve
    cyc(); id(6'b000100, 6'd0, 5'd3, 5'd4); ex(1'b1, 1'b1, 5'd3);
    outs("beq_ld_c1", O_STL);
    cyc(); ex(1'b0, 1'b0, 5'd0); mem(1'b1, 5'd3);
    outs("beq_ld_c2", O_STLB);
    cyc(); mem(1'b0, 5'd0);
    outs("beq_ld_c3", O_BR);
    i_taken = 1'b1;
    outs("beq_ld_taken", O_TAKEN);
    cyc(); i_taken = 1'b0;
    chk("taken_cnt_1", o_taken_count, STATS ? 32'd1 : 32'd0);

    // BNE behind an EX ALU op: one stall, then taken
    id(6'b000101, 6'd0, 5'd5, 5'd6); ex(1'b1, 1'b0, 5'd5);
    outs("bne_alu_c1", O_STL);
    cyc(); ex(1'b0, 1'b0, 5'd0); mem(1'b0, 5'd5);
    outs("bne_memalu_fwd", O_BR);
    i_taken = 1'b1;
    outs("bne_taken", O_TAKEN);
    cyc(); i_taken = 1'b0; id(6'b000000, 6'b100000, 5'd5, 5'd6); mem(1'b0, 5'd0);
    outs("flush_one_cycle", O_NORM);
    chk("taken_cnt_2", o_taken_count, STATS ? 32'd2 : 32'd0);

    // JR on r0, J with unrelated dst, JALR with rt-only match, ADD with match
    cyc(); id(6'b000000, 6'b001000, 5'd0, 5'd0); ex(1'b1, 1'b1, 5'd0);
    outs("jr_r0", O_BR);
    cyc(); id(6'b000010, 6'd0, 5'd7, 5'd7); ex(1'b1, 1'b1, 5'd7);
    outs("j_nosrc", O_BR);
    cyc(); id(6'b000000, 6'b001001, 5'd1, 5'd8); ex(1'b1, 1'b1, 5'd8);
    outs("jalr_rt_ignored", O_BR);
    cyc(); id(6'b000000, 6'b100000, 5'd3, 5'd4); ex(1'b1, 1'b1, 5'd3);
    outs("add_no_stall", O_NORM);

    // MEM load hazard on BEQ: one stall
    cyc(); id(6'b000100, 6'd0, 5'd9, 5'd2); ex(1'b0, 1'b0, 5'd0); mem(1'b1, 5'd9);
    outs("beq_memld_c1", O_STL);
    cyc(); mem(1'b0, 5'd0);
    outs("beq_memld_c2", O_BR);
    chk("stall_cnt_4", o_stall_count, STATS ? 32'd4 : 32'd0);

    // reset in the middle of a load stall
    cyc(); id(6'b000100, 6'd0, 5'd3, 5'd4); ex(1'b1, 1'b1, 5'd3);
    outs("rst_pre_stall", O_STL);
    cyc(); rst = 1'b1;
    outs("rst_in_stall", O_ZERO);
    cyc();
    outs("rst_held", O_ZERO);
    chk("rst_taken_cnt", o_taken_count, 32'd0);
    chk("rst_stall_cnt", o_stall_count, 32'd0);
    rst = 1'b0; id(6'b000000, 6'b100000, 5'd1, 5'd2); ex(1'b0, 1'b0, 5'd0);
    outs("rst_to_idle", O_NORM);

    // freeze during a two-cycle load stall
    cyc(); id(6'b000100, 6'd0, 5'd3, 5'd4); ex(1'b1, 1'b1, 5'd3);
    outs("frz_c1", O_STL);
    cyc(); i_enable = 1'b0; ex(1'b0, 1'b0, 5'd0); mem(1'b1, 5'd3);
    outs("frz_held_a", O_FRZB);
    cyc();
    outs("frz_held_b", O_FRZB);
    i_enable = 1'b1;
    outs("frz_resume", O_STLB);
    cyc(); mem(1'b0, 5'd0);
    outs("frz_done", O_BR);
    chk("frz_stall_cnt", o_stall_count, STATS ? 32'd2 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
